// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode, ALU-op and funct encodings plus datapath widths
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10
  } aluop_e;
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_e;
  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two async read ports, one sync write port, r0 hardwired zero
module mips_regfile
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra1_i,
  output logic [DATA_W-1:0] rd1_o,
  input  logic [REG_AW-1:0] ra2_i,
  output logic [DATA_W-1:0] rd2_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
);
  logic [DATA_W-1:0] mem_q [32];
  assign rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : mem_q[ra2_i];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (we_i && wa_i != '0) begin
      mem_q[wa_i] <= wd_i;
    end
  end
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decodes a MIPS instruction, fetches operands and holds the
// result bundle in a valid/ready output register; also owns the write-back port.
module operand_fetch_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        OpALU,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [REG_AW-1:0] dest_reg,
  output logic              illegal
);
  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rs_rf, rt_rf, rs_v, rt_v, imm_x;
  logic [DATA_W-1:0] a_d, b_d, a_q, b_q;
  logic [REG_AW-1:0] dest_d, dest_q;
  logic [5:0]        fn_d, fn_q;
  aluop_e            op_d, op_q;
  logic              ill_d, ill_q, accept;
  ostate_e           state_q;
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign imm_x  = sext16(instr[15:0]);
  mips_regfile u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1_i (rs),
    .rd1_o (rs_rf),
    .ra2_i (rt),
    .rd2_o (rt_rf),
    .we_i  (wb_en),
    .wa_i  (wb_addr),
    .wd_i  (wb_data)
  );
  // Same-cycle write-back forwards into the operand being snapshotted
  assign rs_v = (wb_en && rs != '0 && wb_addr == rs) ? wb_data : rs_rf;
  assign rt_v = (wb_en && rt != '0 && wb_addr == rt) ? wb_data : rt_rf;
  always_comb begin
    ill_d  = 1'b0;
    op_d   = ALUOP_ADD;
    fn_d   = FN_ADD;
    a_d    = rs_v;
    b_d    = imm_x;
    dest_d = '0;
    case (opcode)
      OP_RTYPE: begin
        op_d   = ALUOP_RTYPE;
        fn_d   = instr[5:0];
        b_d    = rt_v;
        dest_d = rd;
      end
      OP_LW, OP_ADDI: dest_d = rt;
      OP_SW: dest_d = '0;
      OP_BEQ: begin
        op_d = ALUOP_SUB;
        fn_d = FN_SUB;
        b_d  = rt_v;
      end
      default: begin
        ill_d = 1'b1;
        fn_d  = '0;
        a_d   = '0;
        b_d   = '0;
      end
    endcase
  end
  assign out_valid   = (state_q == ST_FULL);
  assign instr_ready = !out_valid || out_ready;
  assign accept      = instr_valid && instr_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      op_q    <= ALUOP_ADD;
      fn_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dest_q  <= '0;
      ill_q   <= 1'b0;
    end else if (accept) begin
      state_q <= ST_FULL;
      op_q    <= op_d;
      fn_q    <= fn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dest_q  <= dest_d;
      ill_q   <= ill_d;
    end else if (out_ready) begin
      state_q <= ST_EMPTY;
    end
  end
  assign OpALU    = op_q;
  assign funct    = fn_q;
  assign a        = a_q;
  assign b        = b_q;
  assign dest_reg = dest_q;
  assign illegal  = ill_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed checks of decode, bypass, handshake and reset
module tb_operand_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  OpALU;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic [4:0]  dest_reg;
  logic        illegal;
  int checks = 0;
  int errors = 0;
  localparam logic [31:0] ADD_10_8_9 = 32'h01095020;
  localparam logic [31:0] LW_9_M4_8  = 32'h8D09FFFC;
  localparam logic [31:0] SW_9_M4_8  = 32'hAD09FFFC;
  localparam logic [31:0] BEQ_8_9    = 32'h11090003;
  localparam logic [31:0] ADD_10_0_9 = 32'h00095020;
  localparam logic [31:0] ILL        = {6'b111111, 5'd8, 5'd9, 16'h1234};
  always #5 clk = ~clk;
  operand_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .OpALU       (OpALU),
    .funct       (funct),
    .a           (a),
    .b           (b),
    .dest_reg    (dest_reg),
    .illegal     (illegal)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic bundle(input string tag, input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] ea, input logic [31:0] eb, input logic [4:0] ed,
                        input logic ei);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".OpALU"}, 32'(OpALU), 32'(op));
    chk({tag, ".funct"}, 32'(funct), 32'(fn));
    chk({tag, ".a"}, a, ea);
    chk({tag, ".b"}, b, eb);
    chk({tag, ".dest"}, 32'(dest_reg), 32'(ed));
    chk({tag, ".illegal"}, 32'(illegal), 32'(ei));
  endtask
  task automatic wr(input logic [4:0] ad, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = ad; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask
  logic [15:0] imm;
  logic [31:0] exp_q [$];
  logic [31:0] exp_b;
  int sent, got;
  initial begin
    repeat (2) step();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.OpALU", 32'(OpALU), 32'd0);
    chk("rst.a", a, 32'd0);
    chk("rst.ready", 32'(instr_ready), 32'd1);
    rst_n = 1'b1;
    step();
    wr(5'd8, 32'd5);
    wr(5'd9, 32'd3);
    // back-to-back R, lw, sw, beq at full throughput
    instr_valid = 1'b1; instr = ADD_10_8_9;
    step();
    bundle("add", 2'b10, 6'b100000, 32'd5, 32'd3, 5'd10, 1'b0);
    instr = LW_9_M4_8;
    step();
    bundle("lw", 2'b00, 6'b100000, 32'd5, 32'hFFFFFFFC, 5'd9, 1'b0);
    instr = SW_9_M4_8;
    step();
    bundle("sw", 2'b00, 6'b100000, 32'd5, 32'hFFFFFFFC, 5'd0, 1'b0);
    instr = BEQ_8_9;
    step();
    bundle("beq", 2'b01, 6'b100010, 32'd5, 32'd3, 5'd0, 1'b0);
    instr_valid = 1'b0;
    step();
    chk("drain.valid", 32'(out_valid), 32'd0);
    // backpressure with a write-back to rs while held
    instr_valid = 1'b1; instr = ADD_10_8_9;
    step();
    out_ready = 1'b0; instr = LW_9_M4_8;
    #1;
    chk("bp.ready", 32'(instr_ready), 32'd0);
    wr(5'd8, 32'd100);
    step();
    step();
    bundle("bp.hold", 2'b10, 6'b100000, 32'd5, 32'd3, 5'd10, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(instr_ready), 32'd1);
    step();
    bundle("bp.next", 2'b00, 6'b100000, 32'd100, 32'hFFFFFFFC, 5'd9, 1'b0);
    instr_valid = 1'b0;
    step();
    // random-handshake stream of 20 addi $11,$8,imm
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      imm = 16'(sent * 16'h1357 + 16'h8001);
      instr = {6'b001000, 5'd8, 5'd11, imm};
      instr_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1) == 1;
      #1;
      if (out_valid && out_ready) begin
        exp_b = exp_q.pop_front();
        chk("stream.b", b, exp_b);
        chk("stream.a", a, 32'd100);
        got++;
      end
      if (instr_valid && instr_ready) begin
        exp_q.push_back({{16{imm[15]}}, imm});
        sent++;
      end
      step();
    end
    chk("stream.count", 32'(got), 32'd20);
    instr_valid = 1'b0; out_ready = 1'b1;
    step();
    // bypass on rs, then r0 write ignored and not forwarded
    instr_valid = 1'b1; instr = ADD_10_8_9;
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h77;
    step();
    wb_en = 1'b0; instr_valid = 1'b0;
    bundle("bypass", 2'b10, 6'b100000, 32'h77, 32'd3, 5'd10, 1'b0);
    wr(5'd0, 32'hFF);
    instr_valid = 1'b1; instr = ADD_10_0_9;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFF;
    step();
    wb_en = 1'b0;
    chk("r0.a", a, 32'd0);
    chk("r0.b", b, 32'd3);
    // illegal opcode then a legal one
    instr = ILL;
    step();
    bundle("ill", 2'b00, 6'b000000, 32'd0, 32'd0, 5'd0, 1'b1);
    instr = ADD_10_8_9;
    step();
    bundle("post_ill", 2'b10, 6'b100000, 32'h77, 32'd3, 5'd10, 1'b0);
    // async reset while a bundle is held
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(out_valid), 32'd0);
    chk("midrst.a", a, 32'd0);
    chk("midrst.b", b, 32'd0);
    chk("midrst.OpALU", 32'(OpALU), 32'd0);
    instr_valid = 1'b0; out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    instr_valid = 1'b1; instr = ADD_10_8_9;
    step();
    instr_valid = 1'b0;
    bundle("after_rst", 2'b10, 6'b100000, 32'd0, 32'd0, 5'd10, 1'b0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage directly upstream of the ALU-control + ALU datapath.
- Accepts a 32-bit MIPS instruction, reads a 32x32 register file and decodes the ALU opcode class (OpALU) and funct.
- Produces registered a/b operands and a destination register behind a valid/ready output register.
- Also owns the write-back port into the register file.

Parameters:
- DATA_W, 32, operand/register width (only 32 supported).
- REG_AW, 5, register address width (32 registers).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  upstream instruction valid
- instr  in  32  instruction word (bit 31 = MSB, opcode = [31:26])
- instr_ready  out  1  stage can accept instruction this cycle
- wb_en  in  1  register write enable
- wb_addr  in  5  register write address
- wb_data  in  32  register write data
- out_valid  out  1  output bundle valid
- out_ready  in  1  downstream accepts bundle
- OpALU  out  2  ALU op class to ALU control: 00 add, 01 sub, 10 R-type
- funct  out  6  funct field to ALU control
- a  out  32  operand A
- b  out  32  operand B
- dest_reg  out  5  write-back destination (0 = none)
- illegal  out  1  unsupported opcode flag, qualified by out_valid

Behaviour:
- Reset (async assert, sync release): out_valid=0, OpALU=00, funct=0, a=0, b=0, dest_reg=0, illegal=0; all 32 registers cleared to 0. Reset mid-transfer discards the held bundle.
- Register file:
  - r0 reads 0 always; writes to r0 ignored.
  - Write on rising edge when wb_en=1.
  - Read-during-write bypass: if wb_en=1 and wb_addr equals rs/rt (non-zero) in the accept cycle, wb_data is used for that operand.
- Decode (rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0] sign-extended to 32):
  - opcode 000000 (R-type): OpALU=10, funct=instr[5:0], a=R[rs], b=R[rt], dest=rd.
  - 100011 (lw): OpALU=00, funct=100000, a=R[rs], b=sext(imm), dest=rt.
  - 101011 (sw): OpALU=00, funct=100000, a=R[rs], b=sext(imm), dest=0.
  - 001000 (addi): OpALU=00, funct=100000, a=R[rs], b=sext(imm), dest=rt.
  - 000100 (beq): OpALU=01, funct=100010, a=R[rs], b=R[rt], dest=0.
  - Any other opcode: illegal=1, OpALU=00, funct=0, a=0, b=0, dest=0; still transferred as a normal bundle.
- Handshake: output register has two states.
  - EMPTY (out_valid=0) -> FULL on accept.
  - FULL -> EMPTY when out_ready=1 and no new accept.
  - FULL -> FULL when out_ready=1 with a simultaneous accept (new bundle loaded).
  - FULL stays FULL with outputs frozen when out_ready=0.
  - instr_ready = !out_valid || out_ready (combinational).
  - Accept = instr_valid && instr_ready.
- Latency: 1 cycle from accept to out_valid. Full throughput of 1 instruction/cycle when out_ready=1.
- Operands are snapshotted at accept; a write-back to rs/rt while the bundle is held does not update a/b. Hazard management is outside this block.
- Outputs only change on accept or reset; no glitch-driven change while FULL and stalled.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ
  - OpALU codes ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE
  - funct constants FN_ADD, FN_SUB
  - reg-address/data width constants
- One sub-module: mips_regfile (32x32, two async read ports, one sync write port, async active-low clear, r0 hardwired zero). Bypass muxing stays in operand_fetch_stage.

Test Plan:
- Reset: drive traffic, pull rst_n low mid-transfer -> out_valid=0, a=b=0, OpALU=00 immediately; after release, add $10,$0,$0 gives a=0, b=0.
- R-type: write r8=5, r9=3; send 0x01095020 (add $10,$8,$9) -> next cycle out_valid=1, OpALU=10, funct=100000, a=5, b=3, dest_reg=10.
- I-type: send 0x8D09FFFC (lw $9,-4($8)) -> OpALU=00, funct=100000, a=5, b=0xFFFFFFFC, dest_reg=9; sw with same fields -> dest_reg=0.
- Backpressure: out_ready=0 for 3 cycles with instr_valid=1 -> instr_ready=0, outputs stable; out_ready=1 -> bundle transferred and next instruction accepted in the same cycle, no loss or duplication over a 20-instruction random stream.
- Bypass/r0: wb_en=1, wb_addr=8, wb_data=0x77 in the accept cycle of add $10,$8,$9 -> a=0x77; write wb_addr=0, wb_data=0xFF then read r0 -> 0.
- Illegal: opcode 111111 -> out_valid=1, illegal=1, a=b=0, dest_reg=0; the following legal instruction has illegal=0.
